// File: rtl/rfsoc_config_pkg.sv
// Shared RFSoC configuration defaults and the DAC player state encoding.
package rfsoc_config_pkg;

  localparam int unsigned DEF_SAMPLE_W         = 16;
  localparam int unsigned DEF_SAMPLES_PER_BEAT = 16;
  localparam int unsigned DEF_PS_W             = 32;
  localparam int unsigned DEF_ADDR_W           = 10;
  localparam int unsigned CONFIG_REG_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_PLAY,
    ST_POST
  } player_state_e;

endpackage

// File: rtl/dac_beat_packer.sv
// Packs PS-width words LSB-first into one DAC beat; emits the completed beat
// combinationally on the cycle its last word is accepted.
module dac_beat_packer #(
  parameter int unsigned PS_W   = 32,
  parameter int unsigned BEAT_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [PS_W-1:0]   in_word,
  input  logic              in_valid,
  output logic [BEAT_W-1:0] beat_out,
  output logic              beat_valid
);

  localparam int unsigned WPB   = BEAT_W / PS_W;
  localparam int unsigned CNT_W = (WPB > 1) ? $clog2(WPB) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] pack_q, pack_d;

  always_comb begin
    cnt_d      = cnt_q;
    pack_d     = pack_q;
    beat_out   = pack_q;
    beat_valid = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      pack_d = '0;
    end else if (in_valid) begin
      for (int unsigned i = 0; i < WPB; i++) begin
        if (cnt_q == CNT_W'(i)) beat_out[i*PS_W +: PS_W] = in_word;
      end
      if (cnt_q == CNT_W'(WPB - 1)) begin
        beat_valid = 1'b1;
        cnt_d      = '0;
        pack_d     = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        pack_d = beat_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      pack_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/dac_wave_player.sv
// Per-channel DAC waveform player: beat store loaded from the PS stream and
// a PRE/PLAY/POST sequencer feeding the DAC AXIS stream.
module dac_wave_player
  import rfsoc_config_pkg::*;
#(
  parameter int unsigned SAMPLE_W         = DEF_SAMPLE_W,
  parameter int unsigned SAMPLES_PER_BEAT = DEF_SAMPLES_PER_BEAT,
  parameter int unsigned PS_W             = DEF_PS_W,
  parameter int unsigned ADDR_W           = DEF_ADDR_W,
  parameter int unsigned CFG_W            = CONFIG_REG_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mode,
  input  logic                                 trigger,
  input  logic                                 abort,
  input  logic                                 load_clr,
  input  logic [CFG_W-1:0]                     cfg_cycle_count,
  input  logic [CFG_W-1:0]                     cfg_pre_delay,
  input  logic [CFG_W-1:0]                     cfg_post_delay,
  input  logic [CFG_W-1:0]                     cfg_repeat,
  input  logic [SAMPLE_W*SAMPLES_PER_BEAT-1:0] cfg_mask,
  input  logic                                 cfg_mask_en,
  input  logic [SAMPLE_W*SAMPLES_PER_BEAT-1:0] cfg_lock_wave,
  input  logic [PS_W-1:0]                      s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  output logic [SAMPLE_W*SAMPLES_PER_BEAT-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 busy,
  output logic                                 done,
  output logic [ADDR_W:0]                      beats_loaded
);

  localparam int unsigned BEAT_W = SAMPLE_W * SAMPLES_PER_BEAT;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  player_state_e     state_q, state_d;
  logic [CFG_W-1:0]  cnt_q, cnt_d, runs_q, runs_d;
  logic [CFG_W-1:0]  pre_q, pre_d, cyc_q, cyc_d, post_q, post_d;
  logic [BEAT_W-1:0] mask_q, mask_d;
  logic              mask_en_q, mask_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   loaded_q, loaded_d;
  logic [BEAT_W-1:0] tdata_q, tdata_d, rd_data_q, play_beat, packed_beat;
  logic              tvalid_q, done_q, done_d, trig_prev_q;
  logic              accept, stop, emit, run_end, commit;

  logic [BEAT_W-1:0] mem [DEPTH];

  assign s_axis_tready = rst && !mode && !loaded_q[ADDR_W] && !load_clr;

  dac_beat_packer #(.PS_W(PS_W), .BEAT_W(BEAT_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_clr || mode),
    .in_word    (s_axis_tdata),
    .in_valid   (s_axis_tvalid && s_axis_tready),
    .beat_out   (packed_beat),
    .beat_valid (commit)
  );

  always_comb begin
    loaded_d = loaded_q;
    if (load_clr)    loaded_d = '0;
    else if (commit) loaded_d = loaded_q + (ADDR_W+1)'(1);
  end

  assign accept = trigger && !trig_prev_q && (state_q == ST_IDLE) && mode &&
                  (cfg_cycle_count != '0) && (loaded_q != '0) && m_axis_tready;
  assign stop   = abort || !mode;
  // emit: this edge puts a new sequence beat on tdata
  assign emit   = accept || ((state_q != ST_IDLE) && !stop && m_axis_tready);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    runs_d    = runs_q;
    pre_d     = pre_q;
    cyc_d     = cyc_q;
    post_d    = post_q;
    mask_d    = mask_q;
    mask_en_d = mask_en_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    run_end   = 1'b0;
    if (accept) begin
      pre_d     = cfg_pre_delay;
      cyc_d     = cfg_cycle_count;
      post_d    = cfg_post_delay;
      runs_d    = cfg_repeat;
      mask_d    = cfg_mask;
      mask_en_d = cfg_mask_en;
      cnt_d     = '0;
      state_d   = (cfg_pre_delay != '0) ? ST_PRE : ST_PLAY;
    end else if ((state_q != ST_IDLE) && stop) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      rd_addr_d = '0;
    end else if (emit) begin
      cnt_d = cnt_q + CFG_W'(1);
      case (state_q)
        ST_PRE:  if (cnt_q == pre_q - CFG_W'(1)) begin
                   state_d = ST_PLAY;
                   cnt_d   = '0;
                 end
        ST_PLAY: if (cnt_q == cyc_q - CFG_W'(1)) begin
                   cnt_d = '0;
                   if (post_q != '0) state_d = ST_POST;
                   else              run_end = 1'b1;
                 end
        ST_POST: if (cnt_q == post_q - CFG_W'(1)) begin
                   cnt_d   = '0;
                   run_end = 1'b1;
                 end
        default: ;
      endcase
      if (run_end) begin
        if (runs_q != '0) begin
          runs_d  = runs_q - CFG_W'(1);
          state_d = (pre_q != '0) ? ST_PRE : ST_PLAY;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
    // rd_addr always names the next PLAY beat; rd_data_q already holds it
    if (emit && (state_d == ST_PLAY)) begin
      if (cnt_d == cyc_d - CFG_W'(1))
        rd_addr_d = '0;
      else if ({1'b0, rd_addr_q} == loaded_q - (ADDR_W+1)'(1))
        rd_addr_d = '0;
      else
        rd_addr_d = rd_addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    play_beat = rd_data_q;
    if (mask_en_d) begin
      if (cnt_d == '0)                play_beat = play_beat & mask_d;
      if (cnt_d == cyc_d - CFG_W'(1)) play_beat = play_beat & ~mask_d;
    end
    tdata_d = tdata_q;
    case (state_d)
      ST_IDLE:         tdata_d = cfg_lock_wave;
      ST_PRE, ST_POST: tdata_d = '0;
      ST_PLAY:         if (emit) tdata_d = play_beat;
      default:         tdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      runs_q      <= '0;
      pre_q       <= '0;
      cyc_q       <= '0;
      post_q      <= '0;
      mask_q      <= '0;
      mask_en_q   <= 1'b0;
      rd_addr_q   <= '0;
      loaded_q    <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      runs_q      <= runs_d;
      pre_q       <= pre_d;
      cyc_q       <= cyc_d;
      post_q      <= post_d;
      mask_q      <= mask_d;
      mask_en_q   <= mask_en_d;
      rd_addr_q   <= rd_addr_d;
      loaded_q    <= loaded_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= 1'b1;
      done_q      <= done_d;
      trig_prev_q <= trigger;
    end
  end

  // Registered-output store, write-first on an address collision
  always_ff @(posedge clk) begin
    if (commit) mem[loaded_q[ADDR_W-1:0]] <= packed_beat;
    if (commit && (loaded_q[ADDR_W-1:0] == rd_addr_d)) rd_data_q <= packed_beat;
    else                                               rd_data_q <= mem[rd_addr_d];
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign beats_loaded  = loaded_q;

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed bench for dac_wave_player: table-driven playback sequences plus
// hand-written load/full/clear/reset sequences on a small-depth instance.
module tb_dac_wave_player;

  localparam int unsigned BW = 256;

  logic          clk = 1'b0;
  logic          rst, mode, trigger, abort, load_clr, cfg_mask_en, m_axis_tready;
  logic [31:0]   cfg_cycle_count, cfg_pre_delay, cfg_post_delay, cfg_repeat;
  logic [BW-1:0] cfg_mask, cfg_lock_wave, m_axis_tdata;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, m_axis_tvalid, busy, done;
  logic [10:0]   beats_loaded;

  logic          sm_mode, sm_trigger, sm_load_clr, sm_svalid, sm_sready;
  logic          sm_tvalid, sm_busy, sm_done;
  logic [31:0]   sm_cyc, sm_sdata;
  logic [BW-1:0] sm_tdata;
  logic [2:0]    sm_loaded;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_wave_player u_dut (
    .clk(clk), .rst(rst), .mode(mode), .trigger(trigger), .abort(abort),
    .load_clr(load_clr), .cfg_cycle_count(cfg_cycle_count),
    .cfg_pre_delay(cfg_pre_delay), .cfg_post_delay(cfg_post_delay),
    .cfg_repeat(cfg_repeat), .cfg_mask(cfg_mask), .cfg_mask_en(cfg_mask_en),
    .cfg_lock_wave(cfg_lock_wave), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
    .beats_loaded(beats_loaded)
  );

  dac_wave_player #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .mode(sm_mode), .trigger(sm_trigger), .abort(1'b0),
    .load_clr(sm_load_clr), .cfg_cycle_count(sm_cyc),
    .cfg_pre_delay(cfg_pre_delay), .cfg_post_delay(cfg_post_delay),
    .cfg_repeat(cfg_repeat), .cfg_mask(cfg_mask), .cfg_mask_en(cfg_mask_en),
    .cfg_lock_wave(cfg_lock_wave), .s_axis_tdata(sm_sdata),
    .s_axis_tvalid(sm_svalid), .s_axis_tready(sm_sready),
    .m_axis_tdata(sm_tdata), .m_axis_tvalid(sm_tvalid),
    .m_axis_tready(m_axis_tready), .busy(sm_busy), .done(sm_done),
    .beats_loaded(sm_loaded)
  );

  typedef struct {
    logic          trig;
    logic          abrt;
    logic          rdy;
    logic [BW-1:0] exp_data;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vq[$];

  function automatic logic [BW-1:0] fill(input logic [3:0] h);
    return {64{h}};
  endfunction

  function automatic logic [BW-1:0] half(input logic [3:0] hi, input logic [3:0] lo);
    return {{32{hi}}, {32{lo}}};
  endfunction

  // Expected beat k of one run: pre 2, play 10 over 5 loaded beats, post 2
  function automatic logic [BW-1:0] run_beat(input int k);
    int p;
    logic [3:0] h;
    if (k < 2 || k > 11) return '0;
    p = k - 2;
    h = 4'hA + 4'(p % 5);
    if (p == 0) return half(4'h0, h);
    if (p == 9) return half(h, 4'h0);
    return fill(h);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build(input int runs, input int stall_k, input int busy_trig_k, input int abort_k);
    vq.delete();
    for (int r = 0; r < runs; r++) begin
      for (int k = 0; k < 14; k++) begin
        if (r == 0 && k == abort_k) begin
          vq.push_back('{1'b0, 1'b1, 1'b1, fill(4'h1), 1'b0, 1'b0});
          return;
        end
        vq.push_back('{(r == 0) && (k == 0 || k == busy_trig_k), 1'b0, 1'b1,
                       run_beat(k), 1'b1, 1'b0});
        if (r == 0 && k == stall_k)
          for (int s = 0; s < 3; s++)
            vq.push_back('{1'b0, 1'b0, 1'b0, run_beat(k), 1'b1, 1'b0});
      end
    end
    vq.push_back('{1'b0, 1'b0, 1'b1, fill(4'h1), 1'b0, 1'b1});
    vq.push_back('{1'b0, 1'b0, 1'b1, fill(4'h1), 1'b0, 1'b0});
  endtask

  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      trigger       = vq[i].trig;
      abort         = vq[i].abrt;
      m_axis_tready = vq[i].rdy;
      step();
      chk($sformatf("%s[%0d].tdata", tag, i), m_axis_tdata, vq[i].exp_data);
      chk($sformatf("%s[%0d].busy", tag, i), BW'(busy), BW'(vq[i].exp_busy));
      chk($sformatf("%s[%0d].done", tag, i), BW'(done), BW'(vq[i].exp_done));
    end
    trigger       = 1'b0;
    abort         = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b0; mode = 1'b0; trigger = 1'b0; abort = 1'b0; load_clr = 1'b0;
    cfg_cycle_count = 32'd10; cfg_pre_delay = 32'd2; cfg_post_delay = 32'd2;
    cfg_repeat = '0; cfg_mask = half(4'h0, 4'hF); cfg_mask_en = 1'b1;
    cfg_lock_wave = fill(4'h1); m_axis_tready = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    sm_mode = 1'b0; sm_trigger = 1'b0; sm_load_clr = 1'b0; sm_cyc = 32'd10;
    sm_sdata = '0; sm_svalid = 1'b0;

    step(); step();
    chk("rst.tdata", m_axis_tdata, '0);
    chk("rst.tvalid", BW'(m_axis_tvalid), '0);
    chk("rst.sready", BW'(s_axis_tready), '0);
    chk("rst.busy", BW'(busy), '0);
    chk("rst.done", BW'(done), '0);
    chk("rst.loaded", BW'(beats_loaded), '0);
    chk("rst.sm_sready", BW'(sm_sready), '0);
    rst = 1'b1;
    step();
    chk("idle.tvalid", BW'(m_axis_tvalid), BW'(1));
    chk("idle.tdata", m_axis_tdata, fill(4'h1));

    for (int b = 0; b < 5; b++)
      for (int w = 0; w < 8; w++) begin
        s_axis_tdata  = {8{4'hA + 4'(b)}};
        s_axis_tvalid = 1'b1;
        step();
      end
    s_axis_tvalid = 1'b0;
    chk("load.loaded", BW'(beats_loaded), BW'(5));
    mode = 1'b1;
    step();

    build(1, -1, -1, -1);
    run_table("basic");

    cfg_repeat = 32'd1;
    build(2, -1, 7, -1);
    run_table("repeat");
    cfg_repeat = '0;

    build(1, 4, -1, -1);
    run_table("stall");

    build(1, -1, -1, 6);
    run_table("abort");
    build(1, -1, -1, -1);
    run_table("retrig");

    acc = 0;
    for (int i = 0; i < 32; i++) begin
      sm_sdata  = i;
      sm_svalid = 1'b1;
      if (sm_sready) acc++;
      step();
    end
    chk("full.accepted", BW'(acc), BW'(32));
    chk("full.sready33", BW'(sm_sready), '0);
    chk("full.loaded", BW'(sm_loaded), BW'(4));
    step();
    chk("full.loaded_hold", BW'(sm_loaded), BW'(4));
    sm_svalid   = 1'b0;
    sm_load_clr = 1'b1;
    step();
    chk("clr.loaded", BW'(sm_loaded), '0);
    chk("clr.sready", BW'(sm_sready), '0);
    sm_load_clr = 1'b0;
    sm_mode     = 1'b1;
    sm_trigger  = 1'b1;
    step();
    chk("empty_trig.busy", BW'(sm_busy), '0);
    chk("empty_trig.tdata", sm_tdata, fill(4'h1));
    sm_trigger = 1'b0;
    sm_mode    = 1'b0;
    for (int w = 0; w < 8; w++) begin
      sm_sdata  = 32'h5555_0000 + w;
      sm_svalid = 1'b1;
      step();
    end
    sm_svalid = 1'b0;
    chk("reload.loaded", BW'(sm_loaded), BW'(1));
    sm_mode = 1'b1;
    sm_cyc  = '0;
    step();
    sm_trigger = 1'b1;
    step();
    chk("zero_cyc.busy", BW'(sm_busy), '0);
    sm_trigger = 1'b0;
    sm_cyc     = 32'd10;
    step();
    sm_trigger = 1'b1;
    step();
    chk("good_trig.busy", BW'(sm_busy), BW'(1));
    chk("good_trig.tdata", sm_tdata, '0);
    sm_trigger = 1'b0;

    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(); step(); step();
    chk("midplay.tdata", m_axis_tdata, fill(4'hB));
    rst = 1'b0;
    step();
    chk("midrst.tdata", m_axis_tdata, '0);
    chk("midrst.tvalid", BW'(m_axis_tvalid), '0);
    chk("midrst.busy", BW'(busy), '0);
    chk("midrst.done", BW'(done), '0);
    chk("midrst.loaded", BW'(beats_loaded), '0);
    chk("midrst.sready", BW'(s_axis_tready), '0);
    rst = 1'b1;
    step();
    chk("postrst.tdata", m_axis_tdata, fill(4'h1));
    trigger = 1'b1;
    step();
    chk("postrst_trig.busy", BW'(busy), '0);
    chk("postrst_trig.tdata", m_axis_tdata, fill(4'h1));
    trigger = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
